spio_spinn2aer_pkt_filter: RTL and testbench

SPIO_SPINN2AER_PKT_FILTER -- requirements
Module: spio_spinn2aer_pkt_filter

---
 rtl/spio_spinn2aer_pkt_filter_pkg.sv | 26 ++
 rtl/spio_spinn2aer_pkt_filter_fifo.sv | 79 +++++++
 rtl/spio_spinn2aer_pkt_filter.sv | 82 ++++++++
 tb/tb_spio_spinn2aer_pkt_filter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spio_spinn2aer_pkt_filter_pkg.sv
// Shared SpiNNaker packet layout: width, field positions and type codes.
// The filter and the spinn2aer mapper both use it, so field positions are defined in one place.
package spio_spinn2aer_pkt_filter_pkg;

  localparam int PKT_W    = 72;
  localparam int TYPE_LSB = 6;
  localparam int TYPE_W   = 2;
  localparam int KEY_LSB  = 8;
  localparam int KEY_W    = 32;

  typedef enum logic [1:0] {
    PKT_MC  = 2'b00,
    PKT_P2P = 2'b01,
    PKT_NN  = 2'b10,
    PKT_FR  = 2'b11
  } pkt_type_e;

  function automatic pkt_type_e pkt_type(input logic [PKT_W-1:0] pkt);
    return pkt_type_e'(pkt[TYPE_LSB +: TYPE_W]);
  endfunction

  function automatic logic [KEY_W-1:0] pkt_key(input logic [PKT_W-1:0] pkt);
    return pkt[KEY_LSB +: KEY_W];
  endfunction

endpackage

// File: rtl/spio_spinn2aer_pkt_filter_fifo.sv
// spio_pkt_fifo: DEPTH-entry packet FIFO with registered in_rdy/out_vld/out_dat, 1-cycle latency.
// Backpressure: in_rdy drops after the edge that fills it; head holds while out_rdy is low.
module spio_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_dat,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_dat,
  output logic         out_vld,
  input  logic         out_rdy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic [W-1:0]  dat_q, dat_d;
  logic          push, pop;

  assign push = in_vld & rdy_q;
  assign pop  = vld_q & out_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    vld_d = (cnt_d != '0);
    rdy_d = (cnt_d != CW'(DEPTH));
    // The head register preloads the next head; a push landing on the new
    // head slot (FIFO empty after this edge's pop) must bypass the array.
    dat_d = dat_q;
    if (cnt_d != '0) begin
      dat_d = (push && (wr_ptr_q == rd_ptr_d)) ? in_dat : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b1;
      vld_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      vld_q    <= vld_d;
      dat_q    <= dat_d;
    end
  end

  assign in_rdy  = rdy_q;
  assign out_vld = vld_q;
  assign out_dat = dat_q;

endmodule

// File: rtl/spio_spinn2aer_pkt_filter.sv
// Key/mask filter on MC packets ahead of the spinn2aer mapper, 1-cycle latency through a small FIFO.
// Backpressure: ipkt_rdy low only while the FIFO is full; dropped packets still handshake.
module spio_spinn2aer_pkt_filter
  import spio_spinn2aer_pkt_filter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic             rst,
  input  logic             clk,
  input  logic [PKT_W-1:0] ipkt_data,
  input  logic             ipkt_vld,
  output logic             ipkt_rdy,
  output logic [PKT_W-1:0] opkt_data,
  output logic             opkt_vld,
  input  logic             opkt_rdy,
  input  logic             cfg_en,
  input  logic [31:0]      cfg_key,
  input  logic [31:0]      cfg_mask,
  input  logic             cnt_clr,
  output logic [15:0]      fwd_cnt,
  output logic [15:0]      drop_cnt
);

  logic        accept;
  logic        key_hit;
  logic        pass_pkt;
  logic        fwd;
  logic        drop;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Config is used combinationally, so it only ever affects the packet in its transfer cycle.
  assign key_hit  = ((pkt_key(ipkt_data) ^ cfg_key) & cfg_mask) == '0;
  assign pass_pkt = (pkt_type(ipkt_data) == PKT_MC) && (!cfg_en || key_hit);
  assign accept   = ipkt_vld & ipkt_rdy;
  assign fwd      = accept & pass_pkt;
  assign drop     = accept & ~pass_pkt;

  spio_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PKT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_dat  (ipkt_data),
    .in_vld  (ipkt_vld & pass_pkt),
    .in_rdy  (ipkt_rdy),
    .out_dat (opkt_data),
    .out_vld (opkt_vld),
    .out_rdy (opkt_rdy)
  );

  always_comb begin
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (cnt_clr) begin
      fwd_cnt_d  = '0;
      drop_cnt_d = '0;
    end else begin
      if (fwd && (fwd_cnt_q != 16'hFFFF)) begin
        fwd_cnt_d = fwd_cnt_q + 16'd1;
      end
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign fwd_cnt  = fwd_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_spio_spinn2aer_pkt_filter.sv
// Scoreboard bench for the spinn2aer packet filter: forwarded packets queued on drive, checked on output.
module tb_spio_spinn2aer_pkt_filter;

  logic        rst;
  logic        clk;
  logic [71:0] ipkt_data;
  logic        ipkt_vld;
  logic        ipkt_rdy;
  logic [71:0] opkt_data;
  logic        opkt_vld;
  logic        opkt_rdy;
  logic        cfg_en;
  logic [31:0] cfg_key;
  logic [31:0] cfg_mask;
  logic        cnt_clr;
  logic [15:0] fwd_cnt;
  logic [15:0] drop_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int n_out  = 0;
  logic [71:0] sb[$];
  logic [15:0] exp_fwd  = 16'd0;
  logic [15:0] exp_drop = 16'd0;

  spio_spinn2aer_pkt_filter #(.FIFO_DEPTH(4)) dut (
    .rst       (rst),
    .clk       (clk),
    .ipkt_data (ipkt_data),
    .ipkt_vld  (ipkt_vld),
    .ipkt_rdy  (ipkt_rdy),
    .opkt_data (opkt_data),
    .opkt_vld  (opkt_vld),
    .opkt_rdy  (opkt_rdy),
    .cfg_en    (cfg_en),
    .cfg_key   (cfg_key),
    .cfg_mask  (cfg_mask),
    .cnt_clr   (cnt_clr),
    .fwd_cnt   (fwd_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [71:0] mkpkt(input logic [1:0] t, input logic [31:0] key, input logic [31:0] pay);
    return {pay, key, t, 6'h2a};
  endfunction

  function automatic logic model_fwd(input logic [71:0] pkt);
    logic [31:0] key;
    key = pkt[39:8];
    if (pkt[7:6] != 2'b00) return 1'b0;
    if (!cfg_en) return 1'b1;
    return (key & cfg_mask) == (cfg_key & cfg_mask);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns with the handshake edge passed.
  task automatic send(input logic [71:0] pkt, output int waits);
    waits = 0;
    ipkt_data = pkt;
    ipkt_vld  = 1'b1;
    while (!ipkt_rdy && waits < 200) begin
      tick(1);
      waits++;
    end
    if (!ipkt_rdy) begin
      chk("send_timeout", 72'(ipkt_rdy), 72'd1);
      ipkt_vld = 1'b0;
      return;
    end
    if (model_fwd(pkt)) begin
      sb.push_back(pkt);
      if (exp_fwd != 16'hFFFF) exp_fwd++;
    end else begin
      if (exp_drop != 16'hFFFF) exp_drop++;
    end
    tick(1);
    ipkt_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && opkt_vld && opkt_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 72'(opkt_vld), 72'd0);
      end else begin
        chk("out_data", opkt_data, sb.pop_front());
        n_out++;
      end
    end
  end

  initial begin
    int w;
    int base;
    logic [71:0] d0;
    rst = 1'b1; ipkt_data = '0; ipkt_vld = 1'b0; opkt_rdy = 1'b0;
    cfg_en = 1'b0; cfg_key = '0; cfg_mask = '0; cnt_clr = 1'b0;
    #23;
    chk("rst_ipkt_rdy", 72'(ipkt_rdy), 72'd1);
    chk("rst_opkt_vld", 72'(opkt_vld), 72'd0);
    chk("rst_opkt_data", opkt_data, 72'd0);
    chk("rst_fwd_cnt", 72'(fwd_cnt), 72'd0);
    chk("rst_drop_cnt", 72'(drop_cnt), 72'd0);
    @(posedge clk); #1; rst = 1'b0;
    tick(2);

    // Key/mask match.
    cfg_en = 1'b1; cfg_key = 32'h0000_1200; cfg_mask = 32'hFFFF_FF00; opkt_rdy = 1'b1;
    send(mkpkt(2'b00, 32'h1234, 32'hA0A0_0001), w);
    send(mkpkt(2'b00, 32'h5634, 32'hA0A0_0002), w);
    tick(3);
    chk("match_fwd_cnt", 72'(fwd_cnt), 72'd1);
    chk("match_drop_cnt", 72'(drop_cnt), 72'd1);
    chk("match_n_out", 72'(n_out), 72'd1);

    // Non-MC packet discarded even with filtering off.
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0; exp_fwd = 0; exp_drop = 0;
    cfg_en = 1'b0;
    send(mkpkt(2'b01, 32'h1234, 32'h0), w);
    for (int i = 0; i < 3; i++) begin
      chk("nn_opkt_vld", 72'(opkt_vld), 72'd0);
      tick(1);
    end
    chk("nn_drop_cnt", 72'(drop_cnt), 72'd1);
    chk("nn_fwd_cnt", 72'(fwd_cnt), 72'd0);

    // Fill with output stalled, fifth waits, then drains in order.
    base = n_out;
    opkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(mkpkt(2'b00, 32'h100 + i, 32'hB000 + i), w);
    chk("full_ipkt_rdy", 72'(ipkt_rdy), 72'd0);
    chk("full_opkt_vld", 72'(opkt_vld), 72'd1);
    d0 = opkt_data;
    tick(3);
    chk("stall_stable", opkt_data, d0);
    fork
      send(mkpkt(2'b00, 32'h104, 32'hB004), w);
      begin tick(4); opkt_rdy = 1'b1; end
    join
    tick(8);
    chk("drain_n_out", 72'(n_out - base), 72'd5);
    chk("drain_fwd_cnt", 72'(fwd_cnt), 72'(exp_fwd));

    // Full FIFO then continuous streaming: one packet per cycle.
    opkt_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send(mkpkt(2'b00, 32'h200 + i, 32'hC000 + i), w);
    opkt_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(mkpkt(2'b00, 32'h300 + i, 32'hD000 + i), w);
      if (i > 0) chk("stream_nowait", 72'(w), 72'd0);
    end
    tick(8);
    chk("stream_empty", 72'(opkt_vld), 72'd0);

    // Drop counter saturation and clear priority.
    cnt_clr = 1'b1; tick(1); cnt_clr = 1'b0; exp_fwd = 0; exp_drop = 0;
    for (int i = 0; i < 65534; i++) send(mkpkt(2'b01, 32'(i), 32'h0), w);
    chk("drop_fffe", 72'(drop_cnt), 72'hFFFE);
    for (int i = 0; i < 3; i++) send(mkpkt(2'b01, 32'(i), 32'h0), w);
    chk("drop_sat", 72'(drop_cnt), 72'(exp_drop));
    chk("drop_sat_lit", 72'(drop_cnt), 72'hFFFF);
    ipkt_data = mkpkt(2'b01, 32'h9, 32'h0); ipkt_vld = 1'b1; cnt_clr = 1'b1;
    tick(1);
    ipkt_vld = 1'b0; cnt_clr = 1'b0; exp_drop = 0;
    chk("clr_prio", 72'(drop_cnt), 72'd0);
    chk("clr_fwd", 72'(fwd_cnt), 72'd0);

    // Mid-operation reset discards buffered packets.
    opkt_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send(mkpkt(2'b00, 32'h400 + i, 32'hE000 + i), w);
    chk("pre_rst_vld", 72'(opkt_vld), 72'd1);
    #2; rst = 1'b1; sb.delete();
    #3;
    chk("in_rst_vld", 72'(opkt_vld), 72'd0);
    @(posedge clk); #1; rst = 1'b0; exp_fwd = 0; exp_drop = 0;
    chk("post_rst_ipkt_rdy", 72'(ipkt_rdy), 72'd1);
    chk("post_rst_fwd_cnt", 72'(fwd_cnt), 72'd0);
    chk("post_rst_drop_cnt", 72'(drop_cnt), 72'd0);
    opkt_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_vld", 72'(opkt_vld), 72'd0);
      tick(1);
    end
    base = n_out;
    send(mkpkt(2'b00, 32'h500, 32'hF000), w);
    tick(3);
    chk("post_rst_out", 72'(n_out - base), 72'd1);
    chk("post_rst_fwd", 72'(fwd_cnt), 72'(exp_fwd));

    chk("sb_drain", 72'(sb.size()), 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
